// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the single-ported data memory
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Port encoding used by s_port, lock_port and last_grant: 0 = A, 1 = B.
  logic              lock_valid;
  logic              lock_port;
  logic              last_grant;

  logic              s_valid;
  logic              s_port;
  logic              s_we;
  logic              s_err;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;

  logic              acc;
  logic              sel_b;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (lock_valid) begin
        a_gnt = a_req && !lock_port;
        b_gnt = b_req && lock_port;
      end else if (a_req && b_req) begin
        a_gnt = last_grant;
        b_gnt = !last_grant;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign acc       = a_gnt | b_gnt;
  assign sel_b     = b_gnt;
  assign sel_we    = sel_b ? b_we    : a_we;
  assign sel_lock  = sel_b ? b_lock  : a_lock;
  assign sel_addr  = sel_b ? b_addr  : a_addr;
  assign sel_wdata = sel_b ? b_wdata : a_wdata;

  // Memory strobes are gated by rst_n so a write caught by reset never commits.
  assign mem_addr  = s_valid ? s_addr  : '0;
  assign mem_wdata = s_valid ? s_wdata : '0;
  assign mem_we    = s_valid & s_we  & ~s_err & rst_n;
  assign mem_re    = s_valid & ~s_we & ~s_err & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_port  <= 1'b0;
      last_grant <= 1'b1;
      s_valid    <= 1'b0;
      s_port     <= 1'b0;
      s_we       <= 1'b0;
      s_err      <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
    end else begin
      s_valid <= acc;
      if (acc) begin
        s_port     <= sel_b;
        s_we       <= sel_we;
        s_addr     <= sel_addr;
        s_wdata    <= sel_wdata;
        s_err      <= (sel_addr >= ADDR_W'(DEPTH));
        last_grant <= sel_b;
        // Only the owner can be accepted while locked, so its lock bit decides.
        lock_valid <= sel_lock;
        lock_port  <= sel_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_done  <= 1'b0;
      a_err   <= 1'b0;
      a_rdata <= '0;
      b_done  <= 1'b0;
      b_err   <= 1'b0;
      b_rdata <= '0;
    end else begin
      a_done  <= s_valid && !s_port;
      a_err   <= s_valid && !s_port && s_err;
      a_rdata <= (s_valid && !s_port && !s_we && !s_err) ? mem_rdata : '0;
      b_done  <= s_valid && s_port;
      b_err   <= s_valid && s_port && s_err;
      b_rdata <= (s_valid && s_port && !s_we && !s_err) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a transaction-level reference model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int total = 0;
  int bad   = 0;

  logic [31:0] env_mem   [128];
  logic [31:0] model_mem [128];

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? env_mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) if (mem_we) env_mem[mem_addr[6:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of accepted transfers tagged with their accept cycle.
  typedef struct {
    bit        port;
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        err;
    bit [31:0] rdata;
    int        cyc;
  } txn_t;

  txn_t q[$];
  txn_t t;
  int   owner  = -1;
  bit   last_b = 1'b1;
  int   cyc    = 0;
  bit   mdl_on = 1'b0;
  bit   acc_a  = 1'b0;
  bit   acc_b  = 1'b0;

  always @(negedge clk) if (mdl_on) begin
    bit        ea, eb, e_we, e_re, e_ad, e_ae, e_bd, e_be;
    bit [31:0] e_addr, e_wdata, e_ard, e_brd;
    ea = 0; eb = 0; e_we = 0; e_re = 0; e_ad = 0; e_ae = 0; e_bd = 0; e_be = 0;
    e_addr = 0; e_wdata = 0; e_ard = 0; e_brd = 0;
    if (rst_n) begin
      if (owner >= 0) begin
        ea = a_req && owner == 0;
        eb = b_req && owner == 1;
      end else if (a_req && b_req) begin
        ea = last_b;
        eb = !last_b;
      end else begin
        ea = a_req;
        eb = b_req;
      end
    end
    foreach (q[i]) begin
      if (q[i].cyc == cyc - 1) begin
        e_addr  = q[i].addr;
        e_wdata = q[i].wdata;
        e_we    = rst_n && q[i].we && !q[i].err;
        e_re    = rst_n && !q[i].we && !q[i].err;
      end
      if (q[i].cyc == cyc - 2) begin
        if (!q[i].port) begin e_ad = 1; e_ae = q[i].err; e_ard = q[i].rdata; end
        else            begin e_bd = 1; e_be = q[i].err; e_brd = q[i].rdata; end
      end
    end
    chk("a_gnt", a_gnt, ea);         chk("b_gnt", b_gnt, eb);
    chk("mem_we", mem_we, e_we);     chk("mem_re", mem_re, e_re);
    chk("mem_addr", mem_addr, e_addr); chk("mem_wdata", mem_wdata, e_wdata);
    chk("a_done", a_done, e_ad);     chk("a_err", a_err, e_ae);   chk("a_rdata", a_rdata, e_ard);
    chk("b_done", b_done, e_bd);     chk("b_err", b_err, e_be);   chk("b_rdata", b_rdata, e_brd);

    if (!rst_n) begin
      q.delete();
      owner  = -1;
      last_b = 1'b1;
    end else begin
      foreach (q[i]) if (q[i].cyc == cyc - 1 && !q[i].err) begin
        if (q[i].we) model_mem[q[i].addr[6:0]] = q[i].wdata;
        else         q[i].rdata = model_mem[q[i].addr[6:0]];
      end
      if (ea || eb) begin
        t.port  = eb;
        t.we    = eb ? b_we : a_we;
        t.addr  = eb ? b_addr : a_addr;
        t.wdata = eb ? b_wdata : a_wdata;
        t.err   = t.addr >= 128;
        t.rdata = 0;
        t.cyc   = cyc;
        q.push_back(t);
        last_b = eb;
        owner  = (eb ? b_lock : a_lock) ? int'(eb) : -1;
      end
      while (q.size() > 0 && q[0].cyc < cyc - 1) void'(q.pop_front());
    end
    acc_a = ea;
    acc_b = eb;
    cyc++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      env_mem[i]   = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    env_mem[5]   = 32'hDEAD_BEEF;
    model_mem[5] = 32'hDEAD_BEEF;
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    mdl_on = 1;
    @(negedge clk);
    chk("rst_a_gnt", a_gnt, 0);   chk("rst_a_done", a_done, 0);
    chk("rst_mem_re", mem_re, 0); chk("rst_mem_addr", mem_addr, 0);
    step();
    rst_n = 1;

    // Read of a preloaded word, latency 2.
    a_req = 1; a_we = 0; a_addr = 5;
    @(negedge clk); chk("t1_a_gnt", a_gnt, 1);
    step(); a_req = 0;
    @(negedge clk); chk("t1_mem_re", mem_re, 1); chk("t1_mem_addr", mem_addr, 5);
    step();
    @(negedge clk); chk("t1_a_done", a_done, 1); chk("t1_a_rdata", a_rdata, 32'hDEAD_BEEF);
    step();

    // Round robin under continuous contention, A first after reset.
    do_reset();
    a_req = 1; a_addr = 10; b_req = 1; b_addr = 20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_a_gnt", a_gnt, (i % 2 == 0));
      if (i >= 2) chk("rr_a_done", a_done, (i % 2 == 0));
      step();
    end
    idle(); step(); step();

    // Locked burst keeps B out until release.
    do_reset();
    b_req = 1; b_we = 0; b_addr = 40;
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 1; a_addr = 40 + i; a_wdata = 100 + i; a_lock = (i < 3);
      @(negedge clk); chk("lock_b_gnt", b_gnt, 0);
      step();
    end
    a_req = 0; a_lock = 0;
    @(negedge clk); chk("unlock_b_gnt", b_gnt, 1);
    step(); b_req = 0; step(); step();

    // Out-of-range write.
    do_reset();
    b_req = 1; b_we = 1; b_addr = 128; b_wdata = 32'h1234;
    @(negedge clk); chk("oor_b_gnt", b_gnt, 1);
    step(); b_req = 0;
    @(negedge clk); chk("oor_mem_we", mem_we, 0);
    step();
    @(negedge clk); chk("oor_b_done", b_done, 1); chk("oor_b_err", b_err, 1); chk("oor_b_rdata", b_rdata, 0);
    step();
    chk("oor_mem0", env_mem[0], 32'h1000_0000);

    // Read-after-write across ports.
    do_reset();
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 32'h55;
    step();
    a_req = 0; b_req = 1; b_we = 0; b_addr = 3;
    @(negedge clk); chk("raw_b_gnt", b_gnt, 1);
    step(); b_req = 0; step();
    @(negedge clk); chk("raw_b_done", b_done, 1); chk("raw_b_rdata", b_rdata, 32'h55); chk("raw_b_err", b_err, 0);
    step();

    // Reset drops an in-flight locked write.
    do_reset();
    a_req = 1; a_we = 1; a_addr = 7; a_wdata = 32'hAA; a_lock = 1;
    step();
    a_req = 0; a_lock = 0; rst_n = 0;
    @(negedge clk); chk("rw_mem_we", mem_we, 0);
    step();
    rst_n = 1; b_req = 1; b_we = 0; b_addr = 7;
    @(negedge clk); chk("rw_a_done0", a_done, 0); chk("rw_b_gnt", b_gnt, 1);
    step(); b_req = 0;
    @(negedge clk); chk("rw_a_done1", a_done, 0);
    step();
    @(negedge clk); chk("rw_b_done", b_done, 1); chk("rw_b_rdata", b_rdata, 32'h1000_0007);
    step();
    chk("rw_mem7", env_mem[7], 32'h1000_0007);

    // Mixed traffic, requests held until accepted.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if (!a_req || acc_a) begin
        a_req = ($urandom % 3) != 0; a_we = $urandom % 2; a_lock = ($urandom % 4) == 0;
        a_addr = $urandom_range(0, 131); a_wdata = $urandom;
      end
      if (!b_req || acc_b) begin
        b_req = ($urandom % 3) != 0; b_we = $urandom % 2; b_lock = ($urandom % 4) == 0;
        b_addr = $urandom_range(0, 131); b_wdata = $urandom;
      end
      step();
    end
    idle(); step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
